// File: rtl/raycast_pkg.sv
// Shared types and constants for the ray column sequencer.
package raycast_pkg;

  localparam int unsigned DefaultScreenWidth = 320;
  localparam int unsigned DefaultPoseW       = 16;
  localparam int unsigned StatCntW           = 16;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDone
  } seq_state_t;

  typedef struct packed {
    logic [DefaultPoseW-1:0] pos_x;
    logic [DefaultPoseW-1:0] pos_y;
    logic [DefaultPoseW-1:0] dir_x;
    logic [DefaultPoseW-1:0] dir_y;
    logic [DefaultPoseW-1:0] plane_x;
    logic [DefaultPoseW-1:0] plane_y;
  } pose_t;

endpackage

// File: rtl/ray_column_sequencer_if.sv
// Beat bus from the column sequencer to the ray-calculation stage.
interface ray_column_sequencer_if #(
  parameter int unsigned LANES  = 1,
  parameter int unsigned HW     = 9,
  parameter int unsigned POSE_W = 16
);
  logic                  valid_out;
  logic                  ready_in;
  logic [LANES*HW-1:0]   hcount_out;
  logic [LANES-1:0]      lane_en_out;
  logic                  last_out;
  logic [POSE_W-1:0]     posX_out;
  logic [POSE_W-1:0]     posY_out;
  logic [POSE_W-1:0]     dirX_out;
  logic [POSE_W-1:0]     dirY_out;
  logic [POSE_W-1:0]     planeX_out;
  logic [POSE_W-1:0]     planeY_out;

  modport master (
    output valid_out, hcount_out, lane_en_out, last_out,
    output posX_out, posY_out, dirX_out, dirY_out, planeX_out, planeY_out,
    input  ready_in
  );

  modport slave (
    input  valid_out, hcount_out, lane_en_out, last_out,
    input  posX_out, posY_out, dirX_out, dirY_out, planeX_out, planeY_out,
    output ready_in
  );
endinterface

// File: rtl/ray_seq_stats.sv
// Per-frame stall counter (saturating, cleared at frame start) and wrapping frame counter.
module ray_seq_stats
  import raycast_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                issue_start_i,
  input  logic                stall_i,
  input  logic                frame_done_i,
  output logic [StatCntW-1:0] stall_cnt_o,
  output logic [StatCntW-1:0] frame_cnt_o
);

  logic [StatCntW-1:0] stall_cnt_q, stall_cnt_d;
  logic [StatCntW-1:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    frame_cnt_d = frame_cnt_q;
    if (issue_start_i) begin
      stall_cnt_d = '0;
    end else if (stall_i && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (frame_done_i) begin
      frame_cnt_d = frame_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      frame_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign frame_cnt_o = frame_cnt_q;

endmodule

// File: rtl/ray_column_sequencer.sv
// Issues screen columns per frame to the ray stage with a frozen pose snapshot.
// Optional statistics counters are enabled with RAY_SEQ_STATS_EN.
module ray_column_sequencer
  import raycast_pkg::*;
#(
  parameter int unsigned SCREEN_WIDTH = DefaultScreenWidth,
  parameter int unsigned LANES        = 1,
  parameter int unsigned POSE_W       = DefaultPoseW,
  localparam int unsigned HW          = $clog2(SCREEN_WIDTH)
) (
  input  logic                   pixel_clk_in,
  input  logic                   rst_in,
  input  logic                   new_frame_in,
  input  logic [POSE_W-1:0]      posX_in,
  input  logic [POSE_W-1:0]      posY_in,
  input  logic [POSE_W-1:0]      dirX_in,
  input  logic [POSE_W-1:0]      dirY_in,
  input  logic [POSE_W-1:0]      planeX_in,
  input  logic [POSE_W-1:0]      planeY_in,
  ray_column_sequencer_if.master beat_if,
  output logic                   busy_out,
  output logic                   frame_done_out,
`ifdef RAY_SEQ_STATS_EN
  output logic [StatCntW-1:0]    stall_cnt_out,
  output logic [StatCntW-1:0]    frame_cnt_out,
`endif
  output logic                   overrun_out
);

  localparam logic [HW:0] LanesW = (HW+1)'(LANES);

  seq_state_t              state_q, state_d;
  logic [HW:0]             base_q, base_d;
  logic                    pending_q, pending_d;
  logic                    overrun_q, overrun_d;
  logic [5:0][POSE_W-1:0]  pose_q;
  logic [5:0][POSE_W-1:0]  pose_live;
  logic                    start;
  logic                    frame_done;
  logic                    valid;
  logic                    fire;
  logic                    last;
  logic [LANES*HW-1:0]     hcount;
  logic [LANES-1:0]        lane_en;

  assign pose_live = {planeY_in, planeX_in, dirY_in, dirX_in, posY_in, posX_in};

  assign valid = (state_q == StIssue);
  assign fire  = valid && beat_if.ready_in;
  // Computed in 32 bits so LANES > SCREEN_WIDTH cannot wrap the base.
  assign last  = valid && ((32'(base_q) + LANES) >= SCREEN_WIDTH);

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    pending_d  = pending_q;
    overrun_d  = overrun_q;
    start      = 1'b0;
    frame_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (new_frame_in) start = 1'b1;
      end
      StIssue: begin
        if (new_frame_in) begin
          if (pending_q) overrun_d = 1'b1;
          else           pending_d = 1'b1;
        end
        if (fire) begin
          base_d = base_q + LanesW;
          if (last) state_d = StDone;
        end
      end
      StDone: begin
        frame_done = 1'b1;
        // A fresh request in DONE starts the next frame directly; a second one is dropped.
        if (new_frame_in && pending_q) overrun_d = 1'b1;
        if (pending_q || new_frame_in) start = 1'b1;
        else                           state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (start) begin
      state_d   = StIssue;
      base_d    = '0;
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= StIdle;
      base_q    <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      pose_q    <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      if (start) pose_q <= pose_live;
    end
  end

  always_comb begin
    hcount  = '0;
    lane_en = '0;
    if (valid) begin
      for (int i = 0; i < int'(LANES); i++) begin
        hcount[i*HW +: HW] = HW'(32'(base_q) + unsigned'(i));
        lane_en[i]         = (32'(base_q) + unsigned'(i)) < SCREEN_WIDTH;
      end
    end
  end

  assign beat_if.valid_out   = valid;
  assign beat_if.hcount_out  = hcount;
  assign beat_if.lane_en_out = lane_en;
  assign beat_if.last_out    = last;
  assign beat_if.posX_out    = pose_q[0];
  assign beat_if.posY_out    = pose_q[1];
  assign beat_if.dirX_out    = pose_q[2];
  assign beat_if.dirY_out    = pose_q[3];
  assign beat_if.planeX_out  = pose_q[4];
  assign beat_if.planeY_out  = pose_q[5];

  assign busy_out       = (state_q != StIdle);
  assign frame_done_out = frame_done;
  assign overrun_out    = overrun_q;

`ifdef RAY_SEQ_STATS_EN
  logic stall;
  assign stall = valid && !beat_if.ready_in;

  ray_seq_stats u_stats (
    .clk_i         (pixel_clk_in),
    .rst_i         (rst_in),
    .issue_start_i (start),
    .stall_i       (stall),
    .frame_done_i  (frame_done),
    .stall_cnt_o   (stall_cnt_out),
    .frame_cnt_o   (frame_cnt_out)
  );
`endif

endmodule

// File: tb/tb_ray_column_sequencer.sv
// Randomized bench for ray_column_sequencer: two configurations checked against a frame-level model.
module tb_ray_column_sequencer;
  import raycast_pkg::*;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  logic  nf  = 1'b0;
  logic  r1  = 1'b1;
  logic  r4  = 1'b1;
  pose_t live = '0;
  logic  busy1, done1, ovr1, busy4, done4, ovr4;
`ifdef RAY_SEQ_STATS_EN
  logic [15:0] sc1, fc1, sc4, fc4;
`endif

  always #5 clk = ~clk;

  ray_column_sequencer_if #(.LANES(1), .HW(9), .POSE_W(16)) bus1 ();
  ray_column_sequencer_if #(.LANES(4), .HW(4), .POSE_W(16)) bus4 ();
  assign bus1.ready_in = r1;
  assign bus4.ready_in = r4;

  ray_column_sequencer #(.SCREEN_WIDTH(320), .LANES(1), .POSE_W(16)) dut1 (
    .pixel_clk_in   (clk),
    .rst_in         (rst),
    .new_frame_in   (nf),
    .posX_in        (live.pos_x),
    .posY_in        (live.pos_y),
    .dirX_in        (live.dir_x),
    .dirY_in        (live.dir_y),
    .planeX_in      (live.plane_x),
    .planeY_in      (live.plane_y),
    .beat_if        (bus1),
    .busy_out       (busy1),
    .frame_done_out (done1),
`ifdef RAY_SEQ_STATS_EN
    .stall_cnt_out  (sc1),
    .frame_cnt_out  (fc1),
`endif
    .overrun_out    (ovr1)
  );

  ray_column_sequencer #(.SCREEN_WIDTH(10), .LANES(4), .POSE_W(16)) dut4 (
    .pixel_clk_in   (clk),
    .rst_in         (rst),
    .new_frame_in   (nf),
    .posX_in        (live.pos_x),
    .posY_in        (live.pos_y),
    .dirX_in        (live.dir_x),
    .dirY_in        (live.dir_y),
    .planeX_in      (live.plane_x),
    .planeY_in      (live.plane_y),
    .beat_if        (bus4),
    .busy_out       (busy4),
    .frame_done_out (done4),
`ifdef RAY_SEQ_STATS_EN
    .stall_cnt_out  (sc4),
    .frame_cnt_out  (fc4),
`endif
    .overrun_out    (ovr4)
  );

  // Frame-level model: in_frame / next column / one-cycle done pulse per configuration.
  int unsigned m_sw[2] = '{320, 10};
  int unsigned m_ln[2] = '{1, 4};
  int unsigned m_hw[2] = '{9, 4};
  bit          m_act[2], m_done[2], m_pend[2], m_ovr[2];
  int unsigned m_base[2];
  pose_t       m_pose[2];
  logic [15:0] m_stall[2], m_fcnt[2];

  int unsigned obs_beats[2], obs_done[2], obs_vcyc;
  int unsigned npass = 0, ntotal = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset(input int k);
    m_act[k] = 0; m_done[k] = 0; m_pend[k] = 0; m_ovr[k] = 0;
    m_base[k] = 0; m_pose[k] = '0; m_stall[k] = '0; m_fcnt[k] = '0;
    obs_beats[k] = 0;
  endtask

  task automatic model_step(input int k);
    bit rdy, start, old_pend;
    if (rst) begin
      model_reset(k);
      return;
    end
    rdy      = (k == 0) ? r1 : r4;
    start    = 0;
    old_pend = m_pend[k];
    if (m_done[k]) begin
      m_fcnt[k] = m_fcnt[k] + 16'd1;
      m_done[k] = 0;
      if (nf && old_pend) m_ovr[k] = 1;
      start     = old_pend || nf;
      m_pend[k] = 0;
    end else if (m_act[k]) begin
      if (!rdy && m_stall[k] != 16'hffff) m_stall[k] = m_stall[k] + 16'd1;
      if (nf) begin
        if (old_pend) m_ovr[k] = 1;
        else          m_pend[k] = 1;
      end
      if (rdy) begin
        m_base[k] += m_ln[k];
        if (m_base[k] >= m_sw[k]) begin
          m_act[k]  = 0;
          m_done[k] = 1;
        end
      end
    end else begin
      start = nf;
    end
    if (start) begin
      m_act[k] = 1; m_base[k] = 0; m_pose[k] = live; m_stall[k] = '0; m_pend[k] = 0;
    end
  endtask

  task automatic cmp_inst(input int k, input logic v, input logic [127:0] hc,
                          input logic [127:0] en, input logic lst, input logic bsy,
                          input logic dn, input logic ov, input logic [127:0] ps);
    logic [127:0] ehc, een;
    int unsigned  col;
    string        p;
    p   = (k == 0) ? "d1" : "d4";
    ehc = '0;
    een = '0;
    if (m_act[k]) begin
      for (int i = 0; i < int'(m_ln[k]); i++) begin
        col    = m_base[k] + unsigned'(i);
        ehc    = ehc | (128'(col % (32'd1 << m_hw[k])) << (unsigned'(i) * m_hw[k]));
        een[i] = col < m_sw[k];
      end
    end
    chk({p, "_valid"},   128'(v),   128'(m_act[k]));
    chk({p, "_hcount"},  hc,        ehc);
    chk({p, "_lane_en"}, en,        een);
    chk({p, "_last"},    128'(lst), 128'(m_act[k] && (m_base[k] + m_ln[k] >= m_sw[k])));
    chk({p, "_busy"},    128'(bsy), 128'(m_act[k] || m_done[k]));
    chk({p, "_done"},    128'(dn),  128'(m_done[k]));
    chk({p, "_overrun"}, 128'(ov),  128'(m_ovr[k]));
    chk({p, "_pose"},    ps,        128'(m_pose[k]));
    if (dn) begin
      chk({p, "_beats_per_frame"}, 128'(obs_beats[k]), 128'((m_sw[k] + m_ln[k] - 1) / m_ln[k]));
      obs_beats[k] = 0;
      obs_done[k]++;
    end
  endtask

  task automatic compare_all();
    cmp_inst(0, bus1.valid_out, 128'(bus1.hcount_out), 128'(bus1.lane_en_out), bus1.last_out,
             busy1, done1, ovr1, 128'({bus1.posX_out, bus1.posY_out, bus1.dirX_out,
             bus1.dirY_out, bus1.planeX_out, bus1.planeY_out}));
    cmp_inst(1, bus4.valid_out, 128'(bus4.hcount_out), 128'(bus4.lane_en_out), bus4.last_out,
             busy4, done4, ovr4, 128'({bus4.posX_out, bus4.posY_out, bus4.dirX_out,
             bus4.dirY_out, bus4.planeX_out, bus4.planeY_out}));
`ifdef RAY_SEQ_STATS_EN
    chk("d1_stall_cnt", 128'(sc1), 128'(m_stall[0]));
    chk("d1_frame_cnt", 128'(fc1), 128'(m_fcnt[0]));
    chk("d4_stall_cnt", 128'(sc4), 128'(m_stall[1]));
    chk("d4_frame_cnt", 128'(fc4), 128'(m_fcnt[1]));
`endif
  endtask

  // One clock: check at negedge, drive inputs, advance the model on posedge.
  task automatic cycle(input bit f, input bit a, input bit b);
    @(negedge clk);
    compare_all();
    nf   = f;
    r1   = a;
    r4   = b;
    live = pose_t'({$urandom, $urandom, $urandom});
    if (bus1.valid_out) obs_vcyc++;
    if (bus1.valid_out && a) begin
      obs_beats[0]++;
      if (bus1.last_out) chk("d1_last_col_319", 128'(bus1.hcount_out), 128'(319));
    end
    if (bus4.valid_out && b) begin
      obs_beats[1]++;
      if (bus4.last_out) begin
        chk("d4_last_lane_en", 128'(bus4.lane_en_out), 128'(4'b0011));
        chk("d4_last_cols", 128'(bus4.hcount_out[7:0]), 128'(8'h98));
      end
    end
    @(posedge clk);
    model_step(0);
    model_step(1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"},   128'(bus1.valid_out),   '0);
    chk({tag, "_hcount"},  128'(bus1.hcount_out),  '0);
    chk({tag, "_lane_en"}, 128'(bus1.lane_en_out), '0);
    chk({tag, "_last"},    128'(bus1.last_out),    '0);
    chk({tag, "_busy"},    128'(busy1),            '0);
    chk({tag, "_done"},    128'(done1),            '0);
    chk({tag, "_overrun"}, 128'(ovr1),             '0);
    chk({tag, "_pose"},    128'({bus1.posX_out, bus1.planeY_out}), '0);
  endtask

  initial begin
    bit found;
    model_reset(0);
    model_reset(1);
    obs_done = '{0, 0};
    obs_vcyc = 0;
    for (int i = 0; i < 3; i++) cycle(0, 1, 1);
    #1 check_all_zero("reset");
    rst = 0;

    // Frame A: request in the first cycle after release, full-rate ready.
    cycle(1, 1, 1);
    #1;
    chk("latency_valid", 128'(bus1.valid_out), 128'(1));
    chk("latency_col0", 128'(bus1.hcount_out), 128'(0));
    for (int i = 0; i < 330; i++) cycle(0, 1, 1);
    chk("frameA_done_count", 128'(obs_done[0]), 128'(1));

    // Frame B: ready toggles, pose changes every cycle.
    obs_vcyc = 0;
    for (int k = 0; k < 660; k++) cycle(k == 0, (k % 2) == 0, 1);
    chk("toggle_valid_cycles", 128'(obs_vcyc), 128'(640));

    // Frame C: two requests mid-frame -> one back-to-back frame plus overrun.
    obs_done[0] = 0;
    cycle(1, 1, 1);
    for (int i = 0; i < 50; i++) cycle(0, 1, 1);
    cycle(1, 1, 1);
    for (int i = 0; i < 10; i++) cycle(0, 1, 1);
    cycle(1, 1, 1);
    for (int i = 0; i < 700; i++) cycle(0, 1, 1);
    chk("b2b_done_count", 128'(obs_done[0]), 128'(2));
    chk("b2b_overrun", 128'(ovr1), 128'(1));

    // Random traffic.
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 99) < 3, ($urandom % 4) != 0, ($urandom % 4) != 0);

    // Asynchronous reset at column 100.
    cycle(0, 1, 1);
    rst = 1;
    model_reset(0);
    model_reset(1);
    cycle(0, 1, 1);
    rst = 0;
    cycle(1, 1, 1);
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      #1;
      if (bus1.valid_out && bus1.hcount_out == 9'd100) found = 1;
      else cycle(0, 1, 1);
    end
    chk("reached_col100", 128'(found), 128'(1));
    rst = 1;
    model_reset(0);
    model_reset(1);
    #1 check_all_zero("midreset");
    cycle(0, 1, 1);
    rst = 0;

    // Restart from column 0 with five stalls early in the frame.
    cycle(1, 1, 1);
    #1 chk("restart_col0", 128'({bus1.valid_out, bus1.hcount_out}), 128'({1'b1, 9'd0}));
    for (int i = 0; i < 5; i++) cycle(0, 0, 1);
    for (int i = 0; i < 330; i++) cycle(0, 1, 1);
`ifdef RAY_SEQ_STATS_EN
    chk("stats_stall5", 128'(sc1), 128'(5));
    chk("stats_frame1", 128'(fc1), 128'(1));
`endif
    cycle(0, 1, 1);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
